// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter feeding the single TX FIFO write port from two one-entry
// holding slots: an ALU result slot (sent LS byte first) and a reg-file read slot.
module tx_fifo_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_BYTES  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH*ALU_BYTES-1:0] alu_out,
  input  logic                            alu_valid,
  input  logic [DATA_WIDTH-1:0]           rf_rd_data,
  input  logic                            rf_rd_valid,
  input  logic                            fifo_full,
  input  logic                            ovf_clr,
  output logic                            wr_inc,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            alu_slot_busy,
  output logic                            rf_slot_busy,
  output logic                            alu_ovf,
  output logic                            rf_ovf,
  output logic                            arb_idle
);

  localparam int CNT_W = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_RF  = 2'd1,
    SEND_ALU = 2'd2
  } state_t;

  state_t                          r_state;
  logic [CNT_W-1:0]                r_byte_cnt;
  logic                            r_last_rf;
  logic                            r_alu_busy;
  logic                            r_rf_busy;
  logic                            r_alu_ovf;
  logic                            r_rf_ovf;
  logic [DATA_WIDTH*ALU_BYTES-1:0] r_alu_data;
  logic [DATA_WIDTH-1:0]           r_rf_data;

  logic                            w_wr;
  logic                            w_rf_free;
  logic                            w_alu_last;
  logic                            w_alu_free;
  logic [DATA_WIDTH-1:0]           w_alu_byte;

  always_comb begin
    w_alu_byte = '0;
    for (int i = 0; i < ALU_BYTES; i++) begin
      if (r_byte_cnt == CNT_W'(i)) w_alu_byte = r_alu_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Strobe is gated by reset so an abandoned packet never leaks a byte.
  assign w_wr       = reset && (r_state != IDLE) && !fifo_full;
  assign w_rf_free  = w_wr && (r_state == SEND_RF);
  assign w_alu_last = (r_byte_cnt == CNT_W'(ALU_BYTES - 1));
  assign w_alu_free = w_wr && (r_state == SEND_ALU) && w_alu_last;

  always_comb begin
    wr_data = '0;
    if (reset) begin
      case (r_state)
        SEND_RF:  wr_data = r_rf_data;
        SEND_ALU: wr_data = w_alu_byte;
        default:  wr_data = '0;
      endcase
    end
  end

  assign wr_inc        = w_wr;
  assign alu_slot_busy = r_alu_busy;
  assign rf_slot_busy  = r_rf_busy;
  assign alu_ovf       = r_alu_ovf;
  assign rf_ovf        = r_rf_ovf;
  assign arb_idle      = (r_state == IDLE) && !r_alu_busy && !r_rf_busy;

  // Slot data registers carry no reset; busy flags qualify them.
  always_ff @(posedge clk) begin
    if (alu_valid && (!r_alu_busy || w_alu_free)) r_alu_data <= alu_out;
    if (rf_rd_valid && (!r_rf_busy || w_rf_free)) r_rf_data <= rf_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alu_busy <= 1'b0;
      r_rf_busy  <= 1'b0;
      r_alu_ovf  <= 1'b0;
      r_rf_ovf   <= 1'b0;
    end else begin
      if (alu_valid) begin
        if (!r_alu_busy || w_alu_free) r_alu_busy <= 1'b1;
        else                           r_alu_ovf  <= 1'b1;
      end else if (w_alu_free) begin
        r_alu_busy <= 1'b0;
      end
      if (rf_rd_valid) begin
        if (!r_rf_busy || w_rf_free) r_rf_busy <= 1'b1;
        else                         r_rf_ovf  <= 1'b1;
      end else if (w_rf_free) begin
        r_rf_busy <= 1'b0;
      end
      if (ovf_clr && !(alu_valid && r_alu_busy && !w_alu_free)) r_alu_ovf <= 1'b0;
      if (ovf_clr && !(rf_rd_valid && r_rf_busy && !w_rf_free)) r_rf_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_last_rf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_alu_busy && r_rf_busy) begin
            if (r_last_rf) begin
              r_state   <= SEND_ALU;
              r_last_rf <= 1'b0;
            end else begin
              r_state   <= SEND_RF;
              r_last_rf <= 1'b1;
            end
          end else if (r_alu_busy) begin
            r_state <= SEND_ALU;
          end else if (r_rf_busy) begin
            r_state <= SEND_RF;
          end
        end
        SEND_RF: begin
          if (w_wr) r_state <= IDLE;
        end
        SEND_ALU: begin
          if (w_wr) begin
            if (w_alu_last) begin
              r_byte_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter: expected FIFO bytes are queued when the
// stimulus is driven and popped by a monitor whenever the DUT strobes a write.
module tb_tx_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] alu_out;
  logic        alu_valid;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic        fifo_full;
  logic        ovf_clr;
  logic        wr_inc;
  logic [7:0]  wr_data;
  logic        alu_slot_busy;
  logic        rf_slot_busy;
  logic        alu_ovf;
  logic        rf_ovf;
  logic        arb_idle;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  tx_fifo_arbiter #(.DATA_WIDTH(8), .ALU_BYTES(2)) dut (
    .clk(clk), .reset(reset), .alu_out(alu_out), .alu_valid(alu_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .fifo_full(fifo_full),
    .ovf_clr(ovf_clr), .wr_inc(wr_inc), .wr_data(wr_data),
    .alu_slot_busy(alu_slot_busy), .rf_slot_busy(rf_slot_busy),
    .alu_ovf(alu_ovf), .rf_ovf(rf_ovf), .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the next queued byte; a strobe with nothing queued is an error.
  always @(negedge clk) begin
    if (wr_inc === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {24'd0, wr_data}, 32'hFFFF_FFFF);
      else chk("wr_data", {24'd0, wr_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((exp_q.size() != 0 || arb_idle !== 1'b1) && k < 40) begin
      tick();
      k++;
    end
    chk(tag, (k < 40), 1);
  endtask

  initial begin
    reset = 1'b0; alu_out = '0; alu_valid = 1'b0; rf_rd_data = '0;
    rf_rd_valid = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
    tick(); tick(); tick();
    chk("rst_wr_inc", wr_inc, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_alu_busy", alu_slot_busy, 0);
    chk("rst_rf_busy", rf_slot_busy, 0);
    chk("rst_ovf", {alu_ovf, rf_ovf}, 0);
    chk("rst_idle", arb_idle, 1);
    reset = 1'b1;
    tick();

    // RF only
    rf_rd_data = 8'hA5; rf_rd_valid = 1'b1; exp_q.push_back(8'hA5);
    tick(); rf_rd_valid = 1'b0;
    chk("rf_busy_after_pulse", rf_slot_busy, 1);
    chk("rf_no_wr_at_grant", wr_inc, 0);
    tick();
    chk("rf_wr_inc", wr_inc, 1);
    chk("rf_wr_data", wr_data, 8'hA5);
    tick();
    chk("rf_wr_done", wr_inc, 0);
    chk("rf_idle_after", arb_idle, 1);

    // ALU split
    alu_out = 16'h1234; alu_valid = 1'b1; exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    tick(); alu_valid = 1'b0;
    tick();
    chk("alu_lo", {wr_inc, wr_data}, {1'b1, 8'h34});
    tick();
    chk("alu_hi", {wr_inc, wr_data}, {1'b1, 8'h12});
    chk("alu_busy_mid", alu_slot_busy, 1);
    tick();
    chk("alu_busy_done", alu_slot_busy, 0);
    chk("alu_idle_after", arb_idle, 1);

    // Tie after reset: RF wins, then ALU after an idle cycle
    reset = 1'b0; tick(); reset = 1'b1; tick();
    alu_out = 16'hBEEF; alu_valid = 1'b1; rf_rd_data = 8'h5A; rf_rd_valid = 1'b1;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    tick(); alu_valid = 1'b0; rf_rd_valid = 1'b0;
    tick();
    chk("tie_first_rf", {wr_inc, wr_data}, {1'b1, 8'h5A});
    tick();
    chk("tie_idle_gap", wr_inc, 0);
    tick();
    chk("tie_alu_lo", {wr_inc, wr_data}, {1'b1, 8'hEF});
    tick();
    chk("tie_alu_hi", {wr_inc, wr_data}, {1'b1, 8'hBE});
    drain("tie_drain");

    // Second tie: ALU now has priority
    alu_out = 16'hCAFE; alu_valid = 1'b1; rf_rd_data = 8'h77; rf_rd_valid = 1'b1;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA); exp_q.push_back(8'h77);
    tick(); alu_valid = 1'b0; rf_rd_valid = 1'b0;
    tick();
    chk("tie2_first_alu", {wr_inc, wr_data}, {1'b1, 8'hFE});
    drain("tie2_drain");

    // Backpressure on ALU byte 0
    alu_out = 16'hABCD; alu_valid = 1'b1; exp_q.push_back(8'hCD); exp_q.push_back(8'hAB);
    tick(); alu_valid = 1'b0; fifo_full = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_wr", wr_inc, 0);
      tick();
    end
    chk("bp_alu_busy", alu_slot_busy, 1);
    fifo_full = 1'b0;
    #1;
    chk("bp_release_lo", {wr_inc, wr_data}, {1'b1, 8'hCD});
    drain("bp_drain");

    // RF overflow under backpressure
    fifo_full = 1'b1;
    rf_rd_data = 8'h22; rf_rd_valid = 1'b1; exp_q.push_back(8'h22);
    tick();
    rf_rd_data = 8'h11;
    tick(); rf_rd_valid = 1'b0;
    chk("ovf_set", rf_ovf, 1);
    chk("ovf_alu_clear", alu_ovf, 0);
    fifo_full = 1'b0;
    drain("ovf_drain");
    chk("ovf_sticky", rf_ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", rf_ovf, 0);

    // New RF pulse on the edge the slot is freed: captured, no overflow
    rf_rd_data = 8'h33; rf_rd_valid = 1'b1; exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    tick(); rf_rd_valid = 1'b0;
    tick();
    chk("refill_wr", wr_inc, 1);
    rf_rd_data = 8'h44; rf_rd_valid = 1'b1;
    tick(); rf_rd_valid = 1'b0;
    chk("refill_busy", rf_slot_busy, 1);
    chk("refill_no_ovf", rf_ovf, 0);
    drain("refill_drain");

    // Reset after ALU byte 0 written: byte 1 is abandoned
    alu_out = 16'h5678; alu_valid = 1'b1; exp_q.push_back(8'h78);
    tick(); alu_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_wr_gated", wr_inc, 0);
    chk("midrst_data_zero", wr_data, 0);
    tick();
    reset = 1'b1;
    chk("midrst_alu_busy", alu_slot_busy, 0);
    chk("midrst_flags", {alu_ovf, rf_ovf}, 0);
    chk("midrst_idle", arb_idle, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
